// File: rtl/voice_mixer.sv
// voice_mixer: fetches NUM_VOICES signed samples with 8-bit pan, accumulates
// pan-weighted left/right sums, then writes one saturated stereo frame
// downstream per frame.
module voice_mixer #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned SEL_W      = 3
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              enable,
  output logic [SEL_W-1:0]  voice_sel,
  output logic              voice_req,
  input  logic              voice_ack,
  input  logic [31:0]       voice_data,
  input  logic [7:0]        voice_pan,
  output logic [63:0]       sample,
  output logic              wrreq,
  input  logic              wrfull,
  output logic [15:0]       clip_cnt
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PAN_W     = 8;
  localparam int unsigned WT_W      = PAN_W + 1;
  localparam int unsigned PROD_W    = 41;
  localparam int unsigned ACC_W     = 44;
  localparam int unsigned SHR       = 8;
  localparam int unsigned SHIFTED_W = ACC_W - SHR;
  localparam int unsigned OVF_W     = SHIFTED_W - DATA_W + 1;
  localparam int unsigned CNT_W     = 16;

  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // control strobes decoded from the FSM
  logic w_voice_req;
  logic w_write;
  logic w_clear;
  logic w_capture;
  logic w_accum;
  logic w_advance;
  logic w_load_out;
  logic w_last;

  // datapath registers
  logic [SEL_W-1:0]         r_sel;
  logic signed [DATA_W-1:0] r_data;
  logic [PAN_W-1:0]         r_pan;
  logic signed [ACC_W-1:0]  r_acc_l;
  logic signed [ACC_W-1:0]  r_acc_r;
  logic [63:0]              r_sample;
  logic                     r_clip;
  logic [CNT_W-1:0]         r_clip_cnt;

  // datapath combinational terms
  logic signed [WT_W-1:0]      w_wt_l;
  logic signed [WT_W-1:0]      w_wt_r;
  logic signed [PROD_W-1:0]    w_prod_l;
  logic signed [PROD_W-1:0]    w_prod_r;
  logic signed [ACC_W-1:0]     w_sum_l;
  logic signed [ACC_W-1:0]     w_sum_r;
  logic signed [SHIFTED_W-1:0] w_shift_l;
  logic signed [SHIFTED_W-1:0] w_shift_r;
  logic [OVF_W-1:0]            w_top_l;
  logic [OVF_W-1:0]            w_top_r;
  logic                        w_ovf_l;
  logic                        w_ovf_r;
  logic [DATA_W-1:0]           w_sat_l;
  logic [DATA_W-1:0]           w_sat_r;

  assign w_last = (r_sel == SEL_W'(NUM_VOICES - 1));

  // state register
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state and control decode
  always_comb begin
    w_next      = r_state;
    w_voice_req = 1'b0;
    w_write     = 1'b0;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    w_accum     = 1'b0;
    w_advance   = 1'b0;
    w_load_out  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (enable && !wrfull) begin
          w_next = REQ;
        end
      end
      REQ: begin
        w_voice_req = 1'b1;
        if (voice_ack) begin
          w_capture = 1'b1;
          w_next    = ACC;
        end
      end
      ACC: begin
        w_accum = 1'b1;
        if (w_last) begin
          w_load_out = 1'b1;
          w_next     = OUT;
        end else begin
          w_advance = 1'b1;
          w_next    = REQ;
        end
      end
      OUT: begin
        w_write = !wrfull;
        if (!wrfull) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // pan weights: left gets 255-pan (the bitwise complement of an 8-bit pan)
  assign w_wt_l   = $signed({1'b0, ~r_pan});
  assign w_wt_r   = $signed({1'b0, r_pan});
  assign w_prod_l = PROD_W'(r_data) * PROD_W'(w_wt_l);
  assign w_prod_r = PROD_W'(r_data) * PROD_W'(w_wt_r);
  assign w_sum_l  = r_acc_l + ACC_W'(w_prod_l);
  assign w_sum_r  = r_acc_r + ACC_W'(w_prod_r);

  // scale down by 256 and detect values outside signed 32-bit range
  assign w_shift_l = SHIFTED_W'(w_sum_l >>> SHR);
  assign w_shift_r = SHIFTED_W'(w_sum_r >>> SHR);
  assign w_top_l   = w_shift_l[SHIFTED_W-1:DATA_W-1];
  assign w_top_r   = w_shift_r[SHIFTED_W-1:DATA_W-1];
  assign w_ovf_l   = !((&w_top_l) || !(|w_top_l));
  assign w_ovf_r   = !((&w_top_r) || !(|w_top_r));
  assign w_sat_l   = w_ovf_l ? (w_shift_l[SHIFTED_W-1] ? SAT_NEG : SAT_POS)
                             : w_shift_l[DATA_W-1:0];
  assign w_sat_r   = w_ovf_r ? (w_shift_r[SHIFTED_W-1] ? SAT_NEG : SAT_POS)
                             : w_shift_r[DATA_W-1:0];

  // voice index: cleared in IDLE, stepped after each non-final accumulate
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_sel <= '0;
    end else if (w_clear) begin
      r_sel <= '0;
    end else if (w_advance) begin
      r_sel <= r_sel + SEL_W'(1);
    end
  end

  // capture voice data/pan on the acknowledged request cycle
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_data <= '0;
      r_pan  <= '0;
    end else if (w_capture) begin
      r_data <= voice_data;
      r_pan  <= voice_pan;
    end
  end

  // left/right accumulators
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (w_clear) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (w_accum) begin
      r_acc_l <= w_sum_l;
      r_acc_r <= w_sum_r;
    end
  end

  // saturated frame and its clip flag, loaded on the final accumulate
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_sample <= '0;
      r_clip   <= 1'b0;
    end else if (w_load_out) begin
      r_sample <= {w_sat_l, w_sat_r};
      r_clip   <= w_ovf_l | w_ovf_r;
    end
  end

  // clipped-frame counter, bumped on the write strobe and sticky at all-ones
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_clip_cnt <= '0;
    end else if (w_write && r_clip && (r_clip_cnt != '1)) begin
      r_clip_cnt <= r_clip_cnt + CNT_W'(1);
    end
  end

  assign voice_sel = r_sel;
  assign voice_req = w_voice_req;
  assign wrreq     = w_write;
  assign sample    = r_sample;
  assign clip_cnt  = r_clip_cnt;

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: scoreboard bench for voice_mixer. A reference model computes
// each frame's expected stereo sample when the frame is set up; the monitor
// pops and compares on every wrreq pulse.
module tb_voice_mixer;

  localparam int N     = 8;
  localparam int SEL_W = 3;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic             clk;
  logic             aclr;
  logic             enable;
  logic [SEL_W-1:0] voice_sel;
  logic             voice_req;
  logic             voice_ack;
  logic [31:0]      voice_data;
  logic [7:0]       voice_pan;
  logic [63:0]      sample;
  logic             wrreq;
  logic             wrfull;
  logic [15:0]      clip_cnt;

  voice_mixer #(.NUM_VOICES(N), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .enable     (enable),
    .voice_sel  (voice_sel),
    .voice_req  (voice_req),
    .voice_ack  (voice_ack),
    .voice_data (voice_data),
    .voice_pan  (voice_pan),
    .sample     (sample),
    .wrreq      (wrreq),
    .wrfull     (wrfull),
    .clip_cnt   (clip_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [31:0] vdata [N];
  logic [7:0]         vpan  [N];
  logic [64:0]        sb [$];

  int          ack_delay    = 0;
  int          exp_sel      = 0;
  int          sel_glitch   = 0;
  int          n_wr         = 0;
  int          cycle        = 0;
  int          last_wr_cyc  = 0;
  int          last_period  = 0;
  logic [15:0] exp_clip     = '0;
  bit          clip_pending = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] sat32(input longint v);
    if (v > MAXV) return {1'b1, 32'h7FFF_FFFF};
    if (v < MINV) return {1'b1, 32'h8000_0000};
    return {1'b0, 32'(v)};
  endfunction

  // reference model: full-precision sums, divide by 256 (floor), clamp
  function automatic logic [64:0] model_frame();
    longint l = 0;
    longint r = 0;
    logic [32:0] sl;
    logic [32:0] sr;
    for (int i = 0; i < N; i++) begin
      l += longint'(vdata[i]) * longint'(255 - int'(vpan[i]));
      r += longint'(vdata[i]) * longint'(int'(vpan[i]));
    end
    sl = sat32(l >>> 8);
    sr = sat32(r >>> 8);
    return {sl[32] | sr[32], sl[31:0], sr[31:0]};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // voice source: answers requests after ack_delay extra cycles, noise otherwise
  initial begin
    int  wcnt     = 0;
    bit  prev_req = 1'b0;
    logic [SEL_W-1:0] prev_sel = '0;
    voice_ack  = 1'b0;
    voice_data = '0;
    voice_pan  = '0;
    forever begin
      @(negedge clk);
      if (voice_req) begin
        if (prev_req && (voice_sel != prev_sel)) sel_glitch++;
        prev_sel = voice_sel;
        if (wcnt >= ack_delay) begin
          voice_ack  = 1'b1;
          voice_data = vdata[voice_sel];
          voice_pan  = vpan[voice_sel];
          check_eq("ack_voice_sel", 64'(voice_sel), 64'(exp_sel));
          exp_sel = (exp_sel + 1) % N;
          wcnt = 0;
        end else begin
          voice_ack  = 1'b0;
          voice_data = $urandom;
          voice_pan  = 8'($urandom);
          wcnt++;
        end
      end else begin
        voice_ack  = 1'($urandom);
        voice_data = $urandom;
        voice_pan  = 8'($urandom);
        wcnt = 0;
      end
      prev_req = voice_req;
    end
  end

  // monitor: sampled just before each rising edge
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      #4;
      cycle++;
      if (clip_pending) begin
        check_eq("clip_cnt", 64'(clip_cnt), 64'(exp_clip));
        clip_pending = 1'b0;
      end
      if (wrreq) begin
        n_wr++;
        last_period = cycle - last_wr_cyc;
        last_wr_cyc = cycle;
        check_eq("wrreq_while_wrfull", 64'(wrfull), 64'(0));
        check_eq("wrreq_expected", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("sample", sample, e[63:0]);
          if (e[64] && exp_clip != 16'hFFFF) exp_clip++;
          clip_pending = 1'b1;
        end
      end
    end
  end

  task automatic wait_wr(input int target, input int budget);
    int k = 0;
    while (n_wr < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("wr_count", 64'(n_wr), 64'(target));
  endtask

  task automatic run_frame();
    int base = n_wr;
    sb.push_back(model_frame());
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_wr(base + 1, 300);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_stream(input int nframes, input int delay, input int exp_period);
    int base = n_wr;
    ack_delay = delay;
    for (int i = 0; i < nframes; i++) sb.push_back(model_frame());
    @(negedge clk);
    enable = 1'b1;
    wait_wr(base + nframes - 1, 100 * nframes);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_wr(base + nframes, 200);
    check_eq("frame_period", 64'(last_period), 64'(exp_period));
    repeat (60) @(negedge clk);
    check_eq("no_frame_after_disable", 64'(n_wr), 64'(base + nframes));
    check_eq("scoreboard_drained", 64'(sb.size()), 64'(0));
    ack_delay = 0;
  endtask

  task automatic fill_random(input int shr);
    for (int i = 0; i < N; i++) begin
      vdata[i] = $signed($urandom) >>> shr;
      vpan[i]  = 8'($urandom);
    end
  endtask

  initial begin
    int base;
    int k;
    int wr_seen;
    logic [63:0] held;

    aclr   = 1'b1;
    enable = 1'b0;
    wrfull = 1'b0;
    for (int i = 0; i < N; i++) begin
      vdata[i] = '0;
      vpan[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_voice_req", 64'(voice_req), 64'(0));
    check_eq("rst_wrreq", 64'(wrreq), 64'(0));
    check_eq("rst_voice_sel", 64'(voice_sel), 64'(0));
    check_eq("rst_sample", sample, 64'(0));
    check_eq("rst_clip_cnt", 64'(clip_cnt), 64'(0));
    aclr = 1'b0;
    repeat (2) @(negedge clk);

    // single voice, full left
    vdata[0] = 32'sh0100_0000;
    run_frame();
    check_eq("single_voice_sample", sample, 64'h00FF_0000_0000_0000);
    check_eq("single_voice_clip", 64'(clip_cnt), 64'(0));

    // positive saturation on both channels
    for (int i = 0; i < N; i++) begin
      vdata[i] = 32'sh7FFF_FFFF;
      vpan[i]  = 8'd128;
    end
    run_frame();
    check_eq("sat_pos_sample", sample, 64'h7FFF_FFFF_7FFF_FFFF);
    check_eq("sat_pos_clip", 64'(clip_cnt), 64'(1));

    // negative saturation on left, silent right
    for (int i = 0; i < N; i++) begin
      vdata[i] = 32'sh8000_0000;
      vpan[i]  = 8'd0;
    end
    run_frame();
    check_eq("sat_neg_sample", sample, 64'h8000_0000_0000_0000);
    check_eq("sat_neg_clip", 64'(clip_cnt), 64'(2));

    // random frames across a range of amplitudes
    for (int f = 0; f < 6; f++) begin
      fill_random(f);
      run_frame();
    end

    // continuous frames with zero-latency ack, enable dropped mid-frame
    fill_random(4);
    run_stream(3, 0, 2 * N + 2);

    // ack on the third request cycle: two extra cycles per voice
    fill_random(5);
    sel_glitch = 0;
    run_stream(3, 2, 2 * N + 2 + 2 * N);
    check_eq("voice_sel_stable", 64'(sel_glitch), 64'(0));

    // backpressure: hold wrfull across OUT for about ten cycles
    fill_random(3);
    base = n_wr;
    wr_seen = 0;
    held = '0;
    sb.push_back(model_frame());
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wrfull = 1'b1;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      #1;
      if (wrreq) wr_seen++;
      if (i == 18) held = sample;
    end
    check_eq("bp_no_wrreq", 64'(wr_seen), 64'(0));
    check_eq("bp_sample_stable", sample, held);
    check_eq("bp_no_frame_yet", 64'(n_wr), 64'(base));
    wrfull = 1'b0;
    wait_wr(base + 1, 20);
    repeat (30) @(negedge clk);
    check_eq("bp_single_write", 64'(n_wr), 64'(base + 1));

    // reset during voice 3 discards the frame
    fill_random(2);
    base = n_wr;
    sb.push_back(model_frame());
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    k = 0;
    while (!(voice_req && voice_sel == 3'd3) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("reached_voice3", 64'(voice_req && voice_sel == 3'd3), 64'(1));
    aclr = 1'b1;
    #1;
    check_eq("aclr_voice_req", 64'(voice_req), 64'(0));
    check_eq("aclr_wrreq", 64'(wrreq), 64'(0));
    check_eq("aclr_voice_sel", 64'(voice_sel), 64'(0));
    check_eq("aclr_sample", sample, 64'(0));
    check_eq("aclr_clip_cnt", 64'(clip_cnt), 64'(0));
    sb.delete();
    exp_clip = '0;
    exp_sel  = 0;
    @(negedge clk);
    aclr = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("aclr_no_write", 64'(n_wr), 64'(base));

    // first frame after reset starts from voice 0
    fill_random(6);
    run_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, number of voices mixed per frame (power of two, 2..16).
REQ-002 SHALL have parameter SEL_W, default 3, width of voice_sel (log2 NUM_VOICES).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port aclr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  high = start new frames; low = idle after current frame.
REQ-006 SHALL have port voice_sel  output  SEL_W  index of voice currently requested.
REQ-007 SHALL have port voice_req  output  1  request for voice_data/voice_pan of voice_sel.
REQ-008 SHALL have port voice_ack  input  1  voice_data/voice_pan valid this cycle.
REQ-009 SHALL have port voice_data  input  32  signed two's-complement voice sample.
REQ-010 SHALL have port voice_pan  input  8  unsigned pan; 0 = full left, 255 = full right.
REQ-011 SHALL have port sample  output  64  stereo frame {left[31:0], right[31:0]} for downstream FIFO.
REQ-012 SHALL have port wrreq  output  1  one-cycle write strobe for sample.
REQ-013 SHALL have port wrfull  input  1  downstream FIFO full; no write while high.
REQ-014 SHALL have port clip_cnt  output  16  count of frames with at least one clipped channel.

Function
REQ-015 SHALL implement states IDLE, REQ, ACC, OUT.
REQ-016 IDLE SHALL clear both accumulators and voice_sel, and move to REQ when enable=1 and wrfull=0; otherwise it SHALL stay in IDLE.
REQ-017 REQ SHALL drive voice_req=1 with voice_sel stable until a cycle with voice_ack=1, SHALL register voice_data/voice_pan in that cycle, and SHALL move to ACC.
REQ-018 voice_req SHALL be 1 only in REQ; voice_ack outside REQ SHALL be ignored.
REQ-019 ACC SHALL add voice_data*(255-voice_pan) to the left accumulator and voice_data*voice_pan to the right accumulator.
  - Pan weights are zero-extended unsigned; products are signed 41-bit.
  - Accumulators are signed 44-bit.
REQ-020 ACC SHALL move to OUT if voice_sel = NUM_VOICES-1; otherwise it SHALL increment voice_sel and return to REQ.
REQ-021 On entering OUT, each channel SHALL be arithmetic-shifted right by 8, then saturated to signed 32-bit (0x7FFFFFFF / 0x80000000) and registered into sample.
REQ-022 In OUT, wrreq SHALL equal NOT wrfull (combinational from state and wrfull).
  - sample SHALL stay stable throughout OUT.
  - When wrreq=1 the state SHALL go to IDLE next cycle; otherwise it SHALL stay in OUT.
REQ-023 wrreq SHALL be 0 in every state except OUT; exactly one wrreq pulse SHALL occur per frame.
REQ-024 clip_cnt SHALL increment by 1 on the wrreq cycle of a frame where either channel saturated, and SHALL hold at 0xFFFF (no wrap).
REQ-025 enable deasserted mid-frame SHALL NOT abort the frame; the frame SHALL complete, including its write, before the block stays in IDLE.
REQ-026 Frame length with voice_ack in the same cycle as voice_req and wrfull=0 SHALL be 2*NUM_VOICES+2 cycles (18 cycles at default), wrreq to wrreq.
REQ-027 Each cycle of voice_ack delay SHALL add exactly one cycle per voice; each cycle of wrfull=1 in OUT SHALL add exactly one cycle.

Reset
REQ-028 aclr=1 SHALL immediately force state IDLE, voice_sel=0, voice_req=0, wrreq=0, sample=0, accumulators=0 and clip_cnt=0.
REQ-029 aclr asserted mid-frame SHALL discard the partial frame with no wrreq, and SHALL restart from voice 0 after release.
REQ-030 After aclr release the first frame SHALL begin in the first cycle in IDLE with enable=1 and wrfull=0.

Verification
REQ-031 Single voice: voice 0 data 0x01000000 pan 0, others 0 -> sample = 0x00FF0000_00000000, clip_cnt 0.
REQ-032 Saturation, positive and negative cases:
  - All voices 0x7FFFFFFF pan 128 -> sample = 0x7FFFFFFF_7FFFFFFF, clip_cnt 1.
  - All voices 0x80000000 pan 0 -> left 0x80000000, right 0x00000000, clip_cnt 2.
REQ-033 Backpressure: wrfull=1 for 10 cycles while in OUT -> wrreq 0 throughout, sample unchanged, then one wrreq pulse; no frame lost or duplicated.
REQ-034 Ack latency 3 cycles per voice -> voice_req/voice_sel held stable; frame period = 2*8+2+2*8 = 34 cycles.
REQ-035 aclr pulsed during voice 3 of a frame -> voice_req drops same cycle, no wrreq, and the next frame starts at voice_sel=0.
REQ-036 Throughput: zero-latency ack, wrfull=0, enable=1 -> wrreq every 18 cycles; enable dropped mid-frame -> that frame completes, then no further wrreq.
